byte_serial_alu: RTL
====================

BYTE_SERIAL_ALU -- requirements
Module: byte_serial_alu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits; SHALL be a multiple of 8 in range 8..64.
REQ-002 Parameter NB (derived, not overridable) SHALL equal XLEN/8, bytes per operand.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_data  input  8  opcode/operand byte stream.
REQ-006 in_valid  input  1  in_data holds a valid byte.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 out_data  output  8  result byte stream, MSB byte first.
REQ-009 out_valid  output  1  out_data holds a valid result byte.
REQ-010 out_ready  input  1  sink accepts out_data this cycle.
REQ-011 out_last  output  1  current out_data is the final (least significant) result byte.
REQ-012 err  output  1  current transaction carries an illegal opcode; valid while out_valid=1.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 A byte transfer on either side SHALL occur only in a cycle where valid and ready are both 1.
REQ-015 FSM states SHALL be IDLE, LOAD_A, LOAD_B, EXEC, SEND.
REQ-016 IDLE: in_ready=1; an accepted byte SHALL be latched as opcode; next state LOAD_A, byte counter cleared.
REQ-017 LOAD_A: in_ready=1; NB accepted bytes SHALL fill operand A MSB byte first; after the NB-th byte, next state LOAD_B with counter cleared.
REQ-018 LOAD_B: same as LOAD_A for operand B; after the NB-th byte, next state EXEC.
REQ-019 EXEC SHALL last exactly one cycle with in_ready=0 and SHALL register result and err; next state SEND.
REQ-020 SEND: out_valid=1, out_data SHALL present result byte NB-1-k for k=0..NB-1; k SHALL advance only on an accepted transfer.
REQ-021 out_data and out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 out_last SHALL be 1 only for k=NB-1; an accepted last byte SHALL return the FSM to IDLE next cycle.
REQ-023 in_ready SHALL be 0 in EXEC and SEND; in_valid in those states SHALL be ignored and nothing latched.
REQ-024 Latency: the first result byte SHALL be valid 2 cycles after acceptance of the last operand B byte (EXEC, then SEND).
REQ-025 Opcodes (XLEN-bit results, wrap-around modulo 2^XLEN): 0x00 ADD A+B; 0x01 SUB A-B; 0x02 SLL A<<sh; 0x03 SLT signed A<B ? 1 : 0; 0x04 SLTU unsigned A<B ? 1 : 0; 0x05 XOR; 0x06 SRL logical A>>sh; 0x07 SRA arithmetic A>>>sh (sign-filled); 0x08 OR; 0x09 AND.
REQ-026 sh SHALL be B[log2(XLEN)-1:0]; upper bits of B SHALL be ignored for shifts.
REQ-027 Any other opcode SHALL give result 0 and err=1; legal opcodes give err=0.
REQ-028 Carry/borrow out SHALL be discarded; no overflow flag.
REQ-029 Byte counters SHALL wrap to 0 when leaving each load/send state; no state SHALL exceed NB transfers.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, clear opcode, A, B, result, counters; from the next cycle outputs SHALL be in_ready=1, out_valid=0, out_last=0, out_data=0x00, err=0, busy=0.
REQ-031 rst SHALL take priority over any simultaneous handshake in any state, including mid-load and mid-send; the partial transaction SHALL be discarded and no byte latched that cycle.

Verification
REQ-032 XLEN=32, send 00, 00 00 00 05, FF FF FF FE with in_valid held, out_ready=1 -> out bytes 00 00 00 03, out_last on 4th, err=0.
REQ-033 XLEN=32, SLT 03 with A=FFFFFFFF, B=00000001 -> 00000001; SLTU 04 same operands -> 00000000; SRA 07 A=80000000, B=00000024 (sh=4) -> F8000000.
REQ-034 XLEN=32, opcode 0x2A, any operands -> result 00000000, err=1 on all four out bytes, then IDLE, next transaction runs normally.
REQ-035 Backpressure: out_ready=0 for 3 cycles on byte 2 -> out_data/out_last held stable, in_ready=0, no byte lost or duplicated; in_valid toggled randomly during load -> same result as REQ-032.
REQ-036 Assert rst for one cycle after 3 bytes of operand A -> next cycle IDLE, in_ready=1, busy=0; fresh ADD 0x00000001+0x00000001 -> 00000002.
REQ-037 XLEN=8 and XLEN=64 builds: ADD FF+01 (XLEN=8) -> 00 single byte with out_last=1; SLL 64-bit A=1, B=0x43 (sh=3) -> 0000000000000008 over 8 bytes.

Source files
------------

// File: rtl/byte_serial_alu.sv
// Byte-serial ALU: takes an opcode byte and two XLEN-bit operands MSB byte first,
// then streams the XLEN-bit result back MSB byte first over a valid/ready handshake.
module byte_serial_alu #(
  parameter int XLEN = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       err,
  output logic       busy
);

  localparam int NB  = XLEN / 8;
  localparam int CW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int SHW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    SEND
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [7:0]        opcode;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   result;
  logic [XLEN-1:0]   alu_res;
  logic              alu_err;
  logic              err_q;
  logic [CW-1:0]     cnt;
  logic [SHW-1:0]    sh;
  logic              in_fire;
  logic              out_fire;
  logic              cnt_last;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign cnt_last = (cnt == LAST_CNT);
  assign sh       = op_b[SHW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Handshake decisions use the raw valid/ready inputs so the ready outputs never feed back into themselves.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && cnt_last) state_n = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid && cnt_last) state_n = EXEC;
      end
      EXEC: begin
        state_n = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = cnt_last;
        if (out_ready && cnt_last) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Operands shift in from the bottom so the first byte received ends up most significant.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode <= 8'h00;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            opcode <= in_data;
            cnt    <= '0;
          end
        end
        LOAD_A: begin
          if (in_fire) begin
            op_a <= (op_a << 8) | XLEN'(in_data);
            cnt  <= cnt_last ? '0 : cnt + CW'(1);
          end
        end
        LOAD_B: begin
          if (in_fire) begin
            op_b <= (op_b << 8) | XLEN'(in_data);
            cnt  <= cnt_last ? '0 : cnt + CW'(1);
          end
        end
        EXEC: begin
          result <= alu_res;
          err_q  <= alu_err;
          cnt    <= '0;
        end
        SEND: begin
          if (out_fire) begin
            result <= result << 8;
            cnt    <= cnt_last ? '0 : cnt + CW'(1);
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  // Shifts only look at the low log2(XLEN) bits of B; unknown opcodes yield zero with err set.
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (opcode)
      8'h00: alu_res = op_a + op_b;
      8'h01: alu_res = op_a - op_b;
      8'h02: alu_res = op_a << sh;
      8'h03: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      8'h04: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      8'h05: alu_res = op_a ^ op_b;
      8'h06: alu_res = op_a >> sh;
      8'h07: alu_res = XLEN'($signed(op_a) >>> sh);
      8'h08: alu_res = op_a | op_b;
      8'h09: alu_res = op_a & op_b;
      default: begin
        alu_res = '0;
        alu_err = 1'b1;
      end
    endcase
  end

  assign out_data = (state == SEND) ? result[XLEN-1 -: 8] : 8'h00;
  assign err      = (state == SEND) & err_q;

endmodule
